// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-2 message-schedule slice.
//   - schedule FSM state encoding
//   - per-standard round counts
//   - small-sigma rotate/shift amounts for 32-bit (SHA-256) and 64-bit
//     (SHA-512) words, with a lookup helper used at elaboration time
package sha2_pkg;

    localparam int unsigned ROUNDS_256 = 64;
    localparam int unsigned ROUNDS_512 = 80;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    // SHA-256 small sigmas
    localparam int unsigned S0_ROT_A_256 = 7;
    localparam int unsigned S0_ROT_B_256 = 18;
    localparam int unsigned S0_SHR_256   = 3;
    localparam int unsigned S1_ROT_A_256 = 17;
    localparam int unsigned S1_ROT_B_256 = 19;
    localparam int unsigned S1_SHR_256   = 10;

    // SHA-512 small sigmas
    localparam int unsigned S0_ROT_A_512 = 1;
    localparam int unsigned S0_ROT_B_512 = 8;
    localparam int unsigned S0_SHR_512   = 7;
    localparam int unsigned S1_ROT_A_512 = 19;
    localparam int unsigned S1_ROT_B_512 = 61;
    localparam int unsigned S1_SHR_512   = 6;

    // which: 0 = first rotate, 1 = second rotate, 2 = logical shift
    function automatic int unsigned sigma_amt(input int unsigned word_w,
                                              input int unsigned sel,
                                              input int unsigned which);
        if (word_w == 64) begin
            if (sel == 0) begin
                if (which == 0) return S0_ROT_A_512;
                if (which == 1) return S0_ROT_B_512;
                return S0_SHR_512;
            end
            if (which == 0) return S1_ROT_A_512;
            if (which == 1) return S1_ROT_B_512;
            return S1_SHR_512;
        end
        if (sel == 0) begin
            if (which == 0) return S0_ROT_A_256;
            if (which == 1) return S0_ROT_B_256;
            return S0_SHR_256;
        end
        if (which == 0) return S1_ROT_A_256;
        if (which == 1) return S1_ROT_B_256;
        return S1_SHR_256;
    endfunction

endpackage

// File: rtl/sha2_msg_schedule_if.sv
// Handshake bundle for the SHA-2 message-schedule expander.
//   in_valid/in_ready/in_word      : message words from the block padder
//   out_valid/out_ready/out_word   : schedule words to the round core
//   out_idx                        : round index of out_word
//   out_last                       : out_word is the final schedule word
// master = environment side, slave = schedule block side.
interface sha2_msg_schedule_if #(
    parameter int unsigned WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic [6:0]        out_idx;
    logic              out_last;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word, out_idx, out_last
    );
endinterface

// File: rtl/sha2_small_sigma.sv
// SHA-2 small sigma function, purely combinational.
//   WORD_W : 32 (SHA-256 amounts) or 64 (SHA-512 amounts)
//   SEL    : 0 = sigma0, 1 = sigma1
// Ports:
//   x : input word
//   y : ROTR(x,a) ^ ROTR(x,b) ^ SHR(x,s)
module sha2_small_sigma
    import sha2_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned SEL    = 0
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);
    localparam int unsigned ROT_A = sigma_amt(WORD_W, SEL, 0);
    localparam int unsigned ROT_B = sigma_amt(WORD_W, SEL, 1);
    localparam int unsigned SHR_N = sigma_amt(WORD_W, SEL, 2);

    logic [WORD_W-1:0] rot_a;
    logic [WORD_W-1:0] rot_b;
    logic [WORD_W-1:0] shr_n;

    always_comb begin
        rot_a = (x >> ROT_A) | (x << (WORD_W - ROT_A));
        rot_b = (x >> ROT_B) | (x << (WORD_W - ROT_B));
        shr_n = x >> SHR_N;
        y     = rot_a ^ rot_b ^ shr_n;
    end
endmodule

// File: rtl/sha2_msg_schedule.sv
// Streaming SHA-2 message-schedule expander.
// Loads one 16-word message block serially (W[0] first), then emits
// W[0..ROUNDS-1], one word per output handshake.
//   WORD_W : 32 (SHA-256) or 64 (SHA-512)
//   ROUNDS : schedule words per block, 16..128
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, discards any partial block
//   bus : slave side of sha2_msg_schedule_if
//         in_*  accepted only in LOAD, out_* valid only in RUN
module sha2_msg_schedule
    import sha2_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ROUNDS = ROUNDS_256
) (
    input  logic                       clk,
    input  logic                       rst,
    sha2_msg_schedule_if.slave         bus
);

    if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
        $fatal(1, "sha2_msg_schedule: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 16 || ROUNDS > 128) begin : g_bad_rounds
        $fatal(1, "sha2_msg_schedule: ROUNDS must be within 16..128");
    end

    localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

    sched_state_t      state_q, state_d;
    logic [4:0]        load_cnt_q, load_cnt_d;
    logic [6:0]        t_cnt_q, t_cnt_d;
    logic [WORD_W-1:0] win_q [16];

    logic              shift_en;
    logic [WORD_W-1:0] w_new;
    logic [WORD_W-1:0] s0_out;
    logic [WORD_W-1:0] s1_out;
    logic [WORD_W-1:0] sched_next;
    logic              last_round;

    sha2_small_sigma #(.WORD_W(WORD_W), .SEL(0)) u_sigma0 (
        .x (win_q[1]),
        .y (s0_out)
    );

    sha2_small_sigma #(.WORD_W(WORD_W), .SEL(1)) u_sigma1 (
        .x (win_q[14]),
        .y (s1_out)
    );

    // Window holds W[t..t+15]; this is W[t+16], wrapping mod 2^WORD_W.
    // Valid for every t, including t<16, since the window starts as the
    // raw message block.
    always_comb begin
        sched_next = s1_out + win_q[9] + s0_out + win_q[0];
    end

    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        t_cnt_d       = t_cnt_q;
        shift_en      = 1'b0;
        w_new         = bus.in_word;
        last_round    = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_word  = '0;
        bus.out_idx   = t_cnt_q;
        bus.out_last  = 1'b0;

        case (state_q)
            ST_LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    shift_en   = 1'b1;
                    w_new      = bus.in_word;
                    load_cnt_d = load_cnt_q + 5'd1;
                    if (load_cnt_q == 5'd15) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                last_round    = (t_cnt_q == LAST_IDX);
                bus.out_valid = 1'b1;
                bus.out_word  = win_q[0];
                bus.out_last  = last_round;
                if (bus.out_ready) begin
                    shift_en = 1'b1;
                    w_new    = sched_next;
                    if (last_round) begin
                        state_d    = ST_LOAD;
                        load_cnt_d = '0;
                        t_cnt_d    = '0;
                    end else begin
                        t_cnt_d = t_cnt_q + 7'd1;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= '0;
            t_cnt_q    <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            t_cnt_q    <= t_cnt_d;
            // Loading and expansion both shift the window down by one.
            if (shift_en) begin
                for (int unsigned i = 0; i < 15; i++) begin
                    win_q[i] <= win_q[i+1];
                end
                win_q[15] <= w_new;
            end
        end
    end

endmodule

// File: tb/tb_sha2_msg_schedule.sv
module tb_sha2_msg_schedule;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha2_msg_schedule_if #(.WORD_W(32)) a ();
    sha2_msg_schedule_if #(.WORD_W(64)) b ();

    sha2_msg_schedule #(.WORD_W(32), .ROUNDS(64)) u_dut256 (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    sha2_msg_schedule #(.WORD_W(64), .ROUNDS(80)) u_dut512 (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    typedef struct {
        logic [63:0] word;
        int          idx;
        bit          last;
    } exp_t;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea;
    exp_t        eb;
    logic [63:0] blk  [16];
    logic [63:0] wexp [80];
    logic [63:0] seen_a [64];
    logic [63:0] seen_b [80];

    always @(posedge clk) cyc++;

    // ---------------- reference model ----------------
    function automatic logic [63:0] mask_of(input int ww);
        return (ww == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int ww);
        logic [63:0] m;
        logic [63:0] v;
        m = mask_of(ww);
        v = x & m;
        return ((v >> n) | (v << (ww - n))) & m;
    endfunction

    function automatic logic [63:0] sig(input logic [63:0] x, input int ww, input bit s1);
        logic [63:0] v;
        v = x & mask_of(ww);
        if (ww == 32)
            return s1 ? (rotr(v, 17, 32) ^ rotr(v, 19, 32) ^ (v >> 10))
                      : (rotr(v, 7, 32)  ^ rotr(v, 18, 32) ^ (v >> 3));
        return s1 ? (rotr(v, 19, 64) ^ rotr(v, 61, 64) ^ (v >> 6))
                  : (rotr(v, 1, 64)  ^ rotr(v, 8, 64)  ^ (v >> 7));
    endfunction

    // Textbook W[t] array form of the schedule.
    task automatic build(input int ww, input int rounds);
        logic [63:0] m;
        m = mask_of(ww);
        for (int t = 0; t < rounds; t++) begin
            if (t < 16) wexp[t] = blk[t] & m;
            else wexp[t] = (sig(wexp[t-2], ww, 1'b1) + wexp[t-7]
                            + sig(wexp[t-15], ww, 1'b0) + wexp[t-16]) & m;
        end
    endtask

    task automatic push_a();
        build(32, 64);
        for (int t = 0; t < 64; t++) qa.push_back('{wexp[t], t, (t == 63)});
    endtask

    task automatic push_b();
        build(64, 80);
        for (int t = 0; t < 80; t++) qb.push_back('{wexp[t], t, (t == 79)});
    endtask

    task automatic set_blk(input logic [63:0] w0, input logic [63:0] w15);
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0]  = w0;
        blk[15] = w15;
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 64; i++) seen_a[i] = '1;
        for (int i = 0; i < 80; i++) seen_b[i] = '1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out, got no event, expected one", name);
    endtask

    // ---------------- drivers ----------------
    task automatic load_a(input int count, input bit keep_valid);
        int n;
        for (int i = 0; i < count; i++) begin
            a.in_valid = 1'b1;
            a.in_word  = blk[i][31:0];
            n = 0;
            while (!a.in_ready && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 200) timeout("load_a");
            @(posedge clk); #1;
        end
        if (!keep_valid) a.in_valid = 1'b0;
    endtask

    task automatic load_b();
        int n;
        for (int i = 0; i < 16; i++) begin
            b.in_valid = 1'b1;
            b.in_word  = blk[i];
            n = 0;
            while (!b.in_ready && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 200) timeout("load_b");
            @(posedge clk); #1;
        end
        b.in_valid = 1'b0;
    endtask

    task automatic wait_idx_a(input int idx);
        int n;
        n = 0;
        while (!(a.out_valid && int'(a.out_idx) == idx) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) timeout("wait_idx_a");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) timeout("drain");
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && a.out_valid && a.out_ready) begin
            vectors++;
            if (qa.size() == 0) begin
                miscompares++;
                $display("FAIL a_unexpected: got idx %0d word %h, expected no output",
                         a.out_idx, a.out_word);
            end else begin
                ea = qa.pop_front();
                if (a.out_word !== ea.word[31:0] || int'(a.out_idx) != ea.idx
                    || a.out_last !== ea.last || a.in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL a_word: got idx %0d word %h last %b in_ready %b, expected idx %0d word %h last %b in_ready 0",
                             a.out_idx, a.out_word, a.out_last, a.in_ready,
                             ea.idx, ea.word[31:0], ea.last);
                end
            end
            if (a.out_idx < 7'd64) seen_a[a.out_idx[5:0]] = {32'h0, a.out_word};
        end
    end

    always @(negedge clk) begin
        if (!rst && b.out_valid && b.out_ready) begin
            vectors++;
            if (qb.size() == 0) begin
                miscompares++;
                $display("FAIL b_unexpected: got idx %0d word %h, expected no output",
                         b.out_idx, b.out_word);
            end else begin
                eb = qb.pop_front();
                if (b.out_word !== eb.word || int'(b.out_idx) != eb.idx
                    || b.out_last !== eb.last || b.in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b_word: got idx %0d word %h last %b in_ready %b, expected idx %0d word %h last %b in_ready 0",
                             b.out_idx, b.out_word, b.out_last, b.in_ready,
                             eb.idx, eb.word, eb.last);
                end
            end
            if (b.out_idx < 7'd80) seen_b[b.out_idx] = b.out_word;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int acc_cyc;

        a.in_valid = 1'b0; a.in_word = '0; a.out_ready = 1'b1;
        b.in_valid = 1'b0; b.in_word = '0; b.out_ready = 1'b1;
        clear_seen();

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready",  64'(a.in_ready),  64'd1);
        check("rst_out_valid", 64'(a.out_valid), 64'd0);
        check("rst_out_word",  64'(a.out_word),  64'd0);
        check("rst_out_idx",   64'(a.out_idx),   64'd0);
        check("rst_out_last",  64'(a.out_last),  64'd0);
        check("rst_b_in_ready", 64'(b.in_ready), 64'd1);

        // SHA-256 "abc" with a 5-cycle stall at t=20
        set_blk(64'h6162_6380, 64'h18);
        load_a(16, 1'b0);
        push_a();
        wait_idx_a(20);
        a.out_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check("stall_word", 64'(a.out_word), wexp[20]);
            check("stall_idx",  64'(a.out_idx),  64'd20);
        end
        a.out_ready = 1'b1;
        drain();
        check("abc_w16", seen_a[16], 64'h6162_6380);
        check("abc_w17", seen_a[17], 64'h000F_0000);

        // all-zero block, then W0=1
        clear_seen();
        set_blk(64'h0, 64'h0);
        load_a(16, 1'b0);
        push_a();
        drain();
        check("zero_w63", seen_a[63], 64'h0);
        set_blk(64'h1, 64'h0);
        load_a(16, 1'b0);
        push_a();
        drain();
        check("one_w16", seen_a[16], 64'h1);

        // reset after 7 loaded words
        set_blk(64'h6162_6380, 64'h18);
        load_a(7, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rstload_in_ready",  64'(a.in_ready),  64'd1);
        check("rstload_out_valid", 64'(a.out_valid), 64'd0);
        check("rstload_out_idx",   64'(a.out_idx),   64'd0);

        // fresh block, reset at t=30
        load_a(16, 1'b0);
        push_a();
        wait_idx_a(30);
        a.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        qa.delete();
        check("rstrun_in_ready",  64'(a.in_ready),  64'd1);
        check("rstrun_out_valid", 64'(a.out_valid), 64'd0);
        check("rstrun_out_idx",   64'(a.out_idx),   64'd0);
        check("rstrun_out_word",  64'(a.out_word),  64'd0);
        a.out_ready = 1'b1;
        clear_seen();
        set_blk(64'h1, 64'h0);
        load_a(16, 1'b0);
        push_a();
        drain();
        check("post_rst_w16", seen_a[16], 64'h1);
        check("post_rst_w17", seen_a[17], 64'h0);

        // back-to-back blocks, in_valid held high
        set_blk(64'h6162_6380, 64'h18);
        push_a();
        load_a(16, 1'b1);
        set_blk(64'h1, 64'h0);
        push_a();
        a.in_word = blk[0][31:0];
        n = 0;
        while (!a.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) timeout("b2b_in_ready");
        acc_cyc = cyc;
        load_a(16, 1'b0);
        // first accept presented in cycle 1, W0 presented in cycle 17
        check("b2b_latency",   64'(cyc - acc_cyc), 64'd16);
        check("b2b_out_valid", 64'(a.out_valid),   64'd1);
        check("b2b_out_idx",   64'(a.out_idx),     64'd0);
        drain();

        // SHA-512 "abc"; W17 = s1(0x18) = ROTR19 ^ ROTR61 ^ SHR6
        clear_seen();
        set_blk(64'h6162_6380_0000_0000, 64'h18);
        load_b();
        push_b();
        drain();
        check("abc512_w16", seen_b[16], 64'h6162_6380_0000_0000);
        check("abc512_w17", seen_b[17], 64'h0003_0000_0000_00C0);

        check("qa_empty", 64'(qa.size()), 64'd0);
        check("qb_empty", 64'(qb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
